// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard that stalls ID on RAW and load-WAW hazards.
// Build option HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_cycles.
module hazard_scoreboard #(
  parameter int REG_NUM    = 16,
  parameter int REG_ADDR_W = 4,
  parameter int WB_DIST    = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  forwarding_en,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic                  pipe_freeze,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  has_src1,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  input  logic                  mem_r_en,
  input  logic                  load_done,
  input  logic [REG_ADDR_W-1:0] load_dest,
  output logic                  hazard_detected,
  output logic [REG_NUM-1:0]    busy_mask,
  output logic [REG_ADDR_W:0]   loads_pending,
  output logic [31:0]           stall_cycles
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WB_DIST - 1);

  logic [1:0]       st  [REG_NUM];
  logic [CNT_W-1:0] cnt [REG_NUM];
  logic [REG_ADDR_W:0] load_cnt;
  logic [1:0] st_src1, st_src2, st_dest, st_ld;
  logic issue, load_issue, load_accept;

  function automatic logic in_range(input logic [REG_ADDR_W-1:0] idx);
    return 32'(idx) < 32'(REG_NUM);
  endfunction

  // Out-of-range indices read as FREE so they can never stall.
  assign st_src1 = in_range(src1)      ? st[src1]      : ST_FREE;
  assign st_src2 = in_range(src2)      ? st[src2]      : ST_FREE;
  assign st_dest = in_range(dest)      ? st[dest]      : ST_FREE;
  assign st_ld   = in_range(load_dest) ? st[load_dest] : ST_FREE;

  always_comb begin
    hazard_detected = id_valid && ((has_src1 && (st_src1 != ST_FREE)) ||
                                   (two_src  && (st_src2 != ST_FREE)) ||
                                   (wb_en    && (st_dest == ST_LOAD)));
  end

  assign issue       = id_valid & ~hazard_detected & ~flush & ~pipe_freeze & wb_en;
  assign load_issue  = issue & mem_r_en & in_range(dest);
  assign load_accept = load_done & (st_ld == ST_LOAD);

  // Priority per entry: issue, then load completion, then countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) begin
        st[r]  <= ST_FREE;
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (issue && (32'(dest) == 32'(r))) begin
          if (mem_r_en) begin
            st[r] <= ST_LOAD;
          end else if (forwarding_en) begin
            st[r] <= ST_FREE;
          end else begin
            st[r]  <= ST_PEND;
            cnt[r] <= CNT_FULL;
          end
        end else if (load_accept && (32'(load_dest) == 32'(r))) begin
          if (forwarding_en || (WB_DIST == 1)) begin
            st[r] <= ST_FREE;
          end else begin
            st[r]  <= ST_PEND;
            cnt[r] <= CNT_LOAD;
          end
        end else if ((st[r] == ST_PEND) && !pipe_freeze) begin
          if (cnt[r] == CNT_W'(1)) st[r] <= ST_FREE;
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
    end else begin
      case ({load_issue, load_accept})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

  assign loads_pending = load_cnt;

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < REG_NUM; r++) busy_mask[r] = (st[r] != ST_FREE);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid && hazard_detected && !pipe_freeze && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared every cycle against a per-register "cycles until readable" model.
module tb_hazard_scoreboard;
  localparam int REG_NUM = 16;
  localparam int AW      = 4;
  localparam int WB_DIST = 2;
  localparam int CW      = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic forwarding_en, id_valid, flush, pipe_freeze;
  logic [AW-1:0] src1, src2, dest, load_dest;
  logic has_src1, two_src, wb_en, mem_r_en, load_done;
  logic hazard_detected;
  logic [REG_NUM-1:0] busy_mask;
  logic [AW:0] loads_pending;
  logic [31:0] stall_cycles;

  hazard_scoreboard #(.REG_NUM(REG_NUM), .REG_ADDR_W(AW), .WB_DIST(WB_DIST), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .forwarding_en(forwarding_en), .id_valid(id_valid),
    .flush(flush), .pipe_freeze(pipe_freeze), .src1(src1), .src2(src2),
    .has_src1(has_src1), .two_src(two_src), .dest(dest), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .load_done(load_done), .load_dest(load_dest),
    .hazard_detected(hazard_detected), .busy_mask(busy_mask),
    .loads_pending(loads_pending), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;
  int hz_seen  = 0;

  // Model: wait[r] = 0 free, N>0 readable after N more unfrozen cycles, -1 waiting for load data.
  int          wait_m [REG_NUM];
  int          loads_m;
  longint      stalls_m;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < REG_NUM; r++) wait_m[r] = 0;
    loads_m  = 0;
    stalls_m = 0;
  endfunction

  function automatic bit model_hazard();
    return id_valid && ((has_src1 && wait_m[src1] != 0) ||
                        (two_src  && wait_m[src2] != 0) ||
                        (wb_en    && wait_m[dest] == -1));
  endfunction

  function automatic longint model_mask();
    longint m = 0;
    for (int r = 0; r < REG_NUM; r++) if (wait_m[r] != 0) m |= (longint'(1) << r);
    return m;
  endfunction

  task automatic idle();
    forwarding_en = 1'b0; id_valid = 1'b0; flush = 1'b0; pipe_freeze = 1'b0;
    src1 = '0; src2 = '0; dest = '0; load_dest = '0;
    has_src1 = 1'b0; two_src = 1'b0; wb_en = 1'b0; mem_r_en = 1'b0; load_done = 1'b0;
  endtask

  // Check current cycle at negedge, then advance the model across the next posedge.
  task automatic step();
    bit hz;
    int nxt [REG_NUM];
    @(negedge clk);
    hz = model_hazard();
    if (hazard_detected) hz_seen++;
    check("hazard", longint'(hazard_detected), longint'(hz));
    check("busy_mask", longint'(busy_mask), model_mask());
    check("loads_pending", longint'(loads_pending), longint'(loads_m));
`ifdef HAZARD_STATS_EN
    check("stall_cycles", longint'(stall_cycles), stalls_m);
`else
    check("stall_cycles", longint'(stall_cycles), 0);
`endif
    for (int r = 0; r < REG_NUM; r++)
      nxt[r] = (wait_m[r] > 0 && !pipe_freeze) ? wait_m[r] - 1 : wait_m[r];
    if (load_done && wait_m[load_dest] == -1) begin
      nxt[load_dest] = forwarding_en ? 0 : WB_DIST - 1;
      loads_m--;
    end
    if (id_valid && !hz && !flush && !pipe_freeze && wb_en) begin
      nxt[dest] = mem_r_en ? -1 : (forwarding_en ? 0 : WB_DIST);
      if (mem_r_en) loads_m++;
    end
    if (id_valid && hz && !pipe_freeze && stalls_m != 64'hFFFF_FFFF) stalls_m++;
    @(posedge clk);
    #1;
    for (int r = 0; r < REG_NUM; r++) wait_m[r] = nxt[r];
  endtask

  task automatic issue_op(input logic [AW-1:0] d, input logic is_load, input logic fwd);
    idle();
    forwarding_en = fwd; id_valid = 1'b1; wb_en = 1'b1; dest = d; mem_r_en = is_load;
    step();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("reset_hazard", longint'(hazard_detected), 0);
    check("reset_mask", longint'(busy_mask), 0);
    check("reset_loads", longint'(loads_pending), 0);
    check("reset_stalls", longint'(stall_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No pending writes: reading r3 never stalls.
    id_valid = 1'b1; has_src1 = 1'b1; src1 = 4'd3;
    step();

    // ALU without forwarding: RAW on r5 stalls exactly WB_DIST cycles.
    issue_op(4'd5, 1'b0, 1'b0);
    idle(); id_valid = 1'b1; has_src1 = 1'b1; src1 = 4'd5;
    hz_seen = 0;
    repeat (4) step();
    check("alu_stall_len", hz_seen, WB_DIST);

    // Load with forwarding on r7, data returns in the 6th stalled cycle.
    issue_op(4'd7, 1'b1, 1'b1);
    idle(); forwarding_en = 1'b1; id_valid = 1'b1; two_src = 1'b1; src2 = 4'd7;
    hz_seen = 0;
    for (int i = 0; i < 6; i++) begin
      load_done = (i == 5); load_dest = 4'd7;
      step();
    end
    load_done = 1'b0;
    step();
    check("load_stall_len", hz_seen, 6);

    // Freeze holds the countdown: 2 + 3 stall cycles.
    issue_op(4'd4, 1'b0, 1'b0);
    idle(); id_valid = 1'b1; has_src1 = 1'b1; src1 = 4'd4;
    hz_seen = 0;
    for (int i = 0; i < 7; i++) begin
      pipe_freeze = (i < 3);
      step();
    end
    check("freeze_stall_len", hz_seen, 5);

    // WAW against a load on r9; a stray load_done for free r2 is ignored.
    issue_op(4'd9, 1'b1, 1'b1);
    idle(); forwarding_en = 1'b1; id_valid = 1'b1; wb_en = 1'b1; dest = 4'd9;
    step(); step();
    load_done = 1'b1; load_dest = 4'd2;
    step();
    load_dest = 4'd9;
    step();
    load_done = 1'b0;
    step();

    // Asynchronous reset in the middle of a load stall.
    issue_op(4'd11, 1'b1, 1'b0);
    idle(); id_valid = 1'b1; has_src1 = 1'b1; src1 = 4'd11;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hazard", longint'(hazard_detected), 0);
    check("midrst_mask", longint'(busy_mask), 0);
    check("midrst_loads", longint'(loads_pending), 0);
    check("midrst_stalls", longint'(stall_cycles), 0);
    model_reset();
    idle();
    #1 rst_n = 1'b1;
    step();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      forwarding_en = 1'($urandom_range(0, 1));
      id_valid      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      pipe_freeze   = ($urandom_range(0, 7) == 0);
      has_src1      = 1'($urandom_range(0, 1));
      two_src       = 1'($urandom_range(0, 1));
      wb_en         = 1'($urandom_range(0, 1));
      mem_r_en      = ($urandom_range(0, 2) == 0);
      src1          = AW'($urandom_range(0, 7));
      src2          = AW'($urandom_range(0, 7));
      dest          = AW'($urandom_range(0, 7));
      load_done     = ($urandom_range(0, 3) == 0);
      load_dest     = AW'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
